// File: rtl/banana_tally.sv
// banana_tally: turns 1->0 transitions of the banana-present mask into a
// two-digit BCD score. Bananas are counted one per cycle in ascending index
// order. Each counted banana produces a collect pulse. When the score wraps
// from 99 to 00, the block raises an extra-life pulse. A collect also starts
// the HUD flash, which stays on for a fixed number of frame ticks.
`timescale 1ns/1ps

module banana_tally #(
  parameter int N_BANANAS    = 5,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BANANAS-1:0] mask_in,
  input  logic                 frame_tick,
  input  logic                 clear_score,
  output logic [3:0]           ones,
  output logic [3:0]           tens,
  output logic                 collect_pulse,
  output logic [2:0]           last_idx,
  output logic                 life_up,
  output logic                 flash
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [N_BANANAS-1:0] MASK_ALL_ONES = {N_BANANAS{1'b1}};
  localparam logic [N_BANANAS-1:0] MASK_NONE     = {N_BANANAS{1'b0}};
  localparam logic [N_BANANAS-1:0] MASK_ONE      = N_BANANAS'(1);
  localparam logic [FLASH_W-1:0]   FLASH_RELOAD  = FLASH_W'(FLASH_FRAMES);
  localparam logic [FLASH_W-1:0]   FLASH_ZERO    = {FLASH_W{1'b0}};
  localparam logic [FLASH_W-1:0]   FLASH_ONE     = FLASH_W'(1);

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_idx(input logic [N_BANANAS-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_BANANAS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Two-digit BCD increment. Result is {wrap, tens, ones}. A ones digit that
  // is 9 or above rolls over, so the digits can never leave 0..9.
  function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
    logic [8:0] r;
    if (o < 4'd9) begin
      r = {1'b0, t, o + 4'd1};
    end else if (t < 4'd9) begin
      r = {1'b0, t + 4'd1, 4'd0};
    end else begin
      r = {1'b1, 4'd0, 4'd0};
    end
    return r;
  endfunction

  state_t               state_r;
  logic [N_BANANAS-1:0] prev_mask_r;
  logic [N_BANANAS-1:0] pending_r;
  logic [FLASH_W-1:0]   flash_cnt_r;

  logic [N_BANANAS-1:0] fall_s;
  logic [N_BANANAS-1:0] served_s;
  logic [N_BANANAS-1:0] pending_next_s;
  logic                 service_s;
  logic [2:0]           served_idx_s;
  logic [8:0]           bcd_next_s;
  logic [FLASH_W-1:0]   flash_next_s;

  // Combinational next-state terms: fall detect, banana selection, score and flash.
  always_comb begin
    fall_s = prev_mask_r & ~mask_in;

    // Isolate the lowest pending bit; only SERVE consumes bananas.
    if (state_r == SERVE) begin
      served_s = pending_r & (~pending_r + MASK_ONE);
    end else begin
      served_s = MASK_NONE;
    end

    service_s      = (served_s != MASK_NONE);
    served_idx_s   = lowest_idx(pending_r);
    pending_next_s = (pending_r | fall_s) & ~served_s;
    bcd_next_s     = bcd_inc(tens, ones);

    // A reload takes priority over a frame-tick decrement in the same cycle.
    if (service_s) begin
      flash_next_s = FLASH_RELOAD;
    end else if (frame_tick && (flash_cnt_r != FLASH_ZERO)) begin
      flash_next_s = flash_cnt_r - FLASH_ONE;
    end else begin
      flash_next_s = flash_cnt_r;
    end
  end

  // Previous mask and pending set. A clear resyncs prev_mask to the live
  // mask, suppressing edge detection during the clear cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_mask_r <= MASK_ALL_ONES;
      pending_r   <= MASK_NONE;
    end else if (clear_score) begin
      prev_mask_r <= mask_in;
      pending_r   <= MASK_NONE;
    end else begin
      prev_mask_r <= mask_in;
      pending_r   <= pending_next_s;
    end
  end

  // HUD flash countdown and its registered enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cnt_r <= FLASH_ZERO;
      flash       <= 1'b0;
    end else if (clear_score) begin
      flash_cnt_r <= FLASH_ZERO;
      flash       <= 1'b0;
    end else begin
      flash_cnt_r <= flash_next_s;
      flash       <= (flash_next_s != FLASH_ZERO);
    end
  end

  // Serve FSM with registered score, collect pulse, last index and life pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      ones          <= 4'd0;
      tens          <= 4'd0;
      collect_pulse <= 1'b0;
      last_idx      <= 3'd0;
      life_up       <= 1'b0;
    end else if (clear_score) begin
      state_r       <= IDLE;
      ones          <= 4'd0;
      tens          <= 4'd0;
      collect_pulse <= 1'b0;
      last_idx      <= last_idx;
      life_up       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          collect_pulse <= 1'b0;
          life_up       <= 1'b0;
          ones          <= ones;
          tens          <= tens;
          last_idx      <= last_idx;
          if (pending_r != MASK_NONE) begin
            state_r <= SERVE;
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE: begin
          if (service_s) begin
            ones          <= bcd_next_s[3:0];
            tens          <= bcd_next_s[7:4];
            life_up       <= bcd_next_s[8];
            last_idx      <= served_idx_s;
            collect_pulse <= 1'b1;
          end else begin
            ones          <= ones;
            tens          <= tens;
            life_up       <= 1'b0;
            last_idx      <= last_idx;
            collect_pulse <= 1'b0;
          end
          if (pending_next_s != MASK_NONE) begin
            state_r <= SERVE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r       <= IDLE;
          ones          <= ones;
          tens          <= tens;
          collect_pulse <= 1'b0;
          last_idx      <= last_idx;
          life_up       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banana_tally.sv
// Directed testbench for banana_tally. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
`timescale 1ns/1ps

module tb_banana_tally;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] mask_in;
  logic       frame_tick;
  logic       clear_score;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       collect_pulse;
  logic [2:0] last_idx;
  logic       life_up;
  logic       flash;

  int checks = 0;
  int errors = 0;

  banana_tally #(
    .N_BANANAS   (5),
    .FLASH_FRAMES(30),
    .FLASH_W     (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mask_in      (mask_in),
    .frame_tick   (frame_tick),
    .clear_score  (clear_score),
    .ones         (ones),
    .tens         (tens),
    .collect_pulse(collect_pulse),
    .last_idx     (last_idx),
    .life_up      (life_up),
    .flash        (flash)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int e_collect, input int e_idx,
                           input int e_tens, input int e_ones, input int e_life,
                           input int e_flash);
    check({tag, "_collect"}, int'(collect_pulse), e_collect);
    check({tag, "_idx"},     int'(last_idx),      e_idx);
    check({tag, "_tens"},    int'(tens),          e_tens);
    check({tag, "_ones"},    int'(ones),          e_ones);
    check({tag, "_life"},    int'(life_up),       e_life);
    check({tag, "_flash"},   int'(flash),         e_flash);
  endtask

  initial begin
    reset       = 1'b1;
    mask_in     = 5'b11111;
    frame_tick  = 1'b0;
    clear_score = 1'b0;
    step(2);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(3);

    // Single fall: two-cycle latency to the collect, then 30-frame flash.
    mask_in = 5'b11110;
    step(1); check("t1_edge_k",  int'(collect_pulse), 0);
    step(1); check("t1_edge_k1", int'(collect_pulse), 0);
    step(1); check_all("t1_first", 1, 0, 0, 1, 0, 1);
    step(1); check("t1_pulse_end", int'(collect_pulse), 0);
    frame_tick = 1'b1;
    step(29); check("t1_flash_tick29", int'(flash), 1);
    step(1);  check("t1_flash_tick30", int'(flash), 0);
    frame_tick = 1'b0;

    // Simultaneous falls on bits 0, 2 and 4 are counted in ascending order.
    mask_in     = 5'b11111;
    clear_score = 1'b1;
    step(1);
    clear_score = 1'b0;
    check_all("t2_clear", 0, 0, 0, 0, 0, 0);
    mask_in = 5'b01010;
    step(2); check("t2_wait", int'(collect_pulse), 0);
    step(1); check_all("t2_b0", 1, 0, 0, 1, 0, 1);
    step(1); check_all("t2_b2", 1, 2, 0, 2, 0, 1);
    step(1); check_all("t2_b4", 1, 4, 0, 3, 0, 1);
    step(1); check_all("t2_done", 0, 4, 0, 3, 0, 1);

    // Bits 1 and 3 then fall. After that, rising edges (upstream reset) are ignored.
    mask_in = 5'b00000;
    step(5); check_all("t4_fall13", 0, 3, 0, 5, 0, 1);
    mask_in = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      step(1); check("t4_rise_nopulse", int'(collect_pulse), 0);
    end
    check("t4_rise_ones", int'(ones), 5);

    // Preload 98, then 99, then wrap to 00 with life_up.
    clear_score = 1'b1;
    step(1);
    clear_score = 1'b0;
    for (int i = 0; i < 98; i++) begin
      mask_in = 5'b11110; step(2);
      mask_in = 5'b11111; step(2);
    end
    check_all("t3_pre98", 0, 0, 9, 8, 0, 1);
    mask_in = 5'b11110; step(2);
    mask_in = 5'b11111; step(1);
    check_all("t3_99", 1, 0, 9, 9, 0, 1);
    step(1);
    mask_in = 5'b11110; step(2);
    mask_in = 5'b11111; step(1);
    check_all("t3_wrap", 1, 0, 0, 0, 1, 1);
    step(1); check_all("t3_after", 0, 0, 0, 0, 0, 1);

    // Score 07 with bits 2 and 4 pending; clear drops them all.
    mask_in = 5'b00000; step(8);
    check_all("t5_five", 0, 4, 0, 5, 0, 1);
    mask_in = 5'b11111; step(2);
    mask_in = 5'b11100; step(6);
    check_all("t5_seven", 0, 1, 0, 7, 0, 1);
    mask_in = 5'b11111; step(2);
    mask_in = 5'b01011; step(1);
    clear_score = 1'b1;
    step(1);
    clear_score = 1'b0;
    check_all("t5_clear", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1); check("t5_dropped", int'(collect_pulse), 0);
    end
    check("t5_ones_kept0", int'(ones), 0);

    // Reload wins over a coincident frame_tick when flash_cnt is 3.
    mask_in = 5'b01010; step(3);
    check_all("t6_svc1", 1, 0, 0, 1, 0, 1);
    mask_in    = 5'b01011;
    frame_tick = 1'b1;
    step(27);
    frame_tick = 1'b0;
    check("t6_cnt3_flash", int'(flash), 1);
    mask_in = 5'b01010; step(2);
    frame_tick = 1'b1; step(1);
    check_all("t6_svc2", 1, 0, 0, 2, 0, 1);
    step(29); check("t6_reload_29", int'(flash), 1);
    step(1);  check("t6_reload_30", int'(flash), 0);
    frame_tick = 1'b0;

    // Reset mid-SERVE discards pending work, and prev_mask returns to all ones.
    mask_in = 5'b01011; step(1);
    mask_in = 5'b00000; step(3);
    check_all("t7_svc", 1, 0, 0, 3, 0, 1);
    reset = 1'b1; step(1);
    check_all("t7_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(2); check("t7_wait", int'(collect_pulse), 0);
    step(1); check_all("t7_first", 1, 0, 0, 1, 0, 1);
    step(4); check_all("t7_fifth", 1, 4, 0, 5, 0, 1);
    step(1); check_all("t7_done", 0, 4, 0, 5, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
